wb_gpio_bank: RTL and testbench

- Parametrised Wishbone-classic GPIO peripheral for the picorv32 Wishbone SoC; board tops route header pins (e.g. GPIO_0) through it instead of hard-wiring single UART pins.
- Generalises fixed pin wiring to GPIO_WIDTH bidirectional channels.
- Per-pin direction control, output register, synchronised input, and per-pin edge-interrupt capture with a masked, level-sensitive irq_o to the CPU.

---
 rtl/wb_gpio_bank.sv | 194 +++++++++++++++++++
 tb/tb_wb_gpio_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank -- Wishbone-classic GPIO peripheral with per-pin direction,
// output register, synchronised input and per-pin edge interrupts.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   wb_adr_i[4:0]       byte address, [4:2] selects the register
//   wb_dat_i/wb_dat_o   write / read data (read data is 0 while ack is low)
//   wb_sel_i[3:0]       byte lane enables for writes
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o   classic handshake, one-cycle ack
//   gpio_i              asynchronous pad inputs
//   gpio_o, gpio_oe     pad output values and enables (1 drives the pad)
//   irq_o               level interrupt, |(STATUS & MASK), registered
//
// Register map: 0x00 IN (RO), 0x04 OUT, 0x08 DIR, 0x0C MASK,
//   0x10 EDGE (1 = rising, 0 = falling), 0x14 STATUS (write 1 to clear),
//   0x18/0x1C read 0, writes ignored.
//
// Optional build macro WB_GPIO_DEBOUNCE_EN inserts a debounce filter of
// DEBOUNCE_CYCLES stable clocks between the synchroniser and IN/edge logic.

module wb_gpio_bank #(
  parameter int GPIO_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq_o
);

  localparam logic [2:0] REG_IN     = 3'd0;
  localparam logic [2:0] REG_OUT    = 3'd1;
  localparam logic [2:0] REG_DIR    = 3'd2;
  localparam logic [2:0] REG_MASK   = 3'd3;
  localparam logic [2:0] REG_EDGE   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  logic                  ack_reg;
  logic [31:0]           dat_reg;
  logic                  irq_reg;
  logic [GPIO_WIDTH-1:0] out_reg;
  logic [GPIO_WIDTH-1:0] dir_reg;
  logic [GPIO_WIDTH-1:0] mask_reg;
  logic [GPIO_WIDTH-1:0] edge_reg;
  logic [GPIO_WIDTH-1:0] status_reg;
  logic [GPIO_WIDTH-1:0] status_next;
  logic [GPIO_WIDTH-1:0] s1_reg;
  logic [GPIO_WIDTH-1:0] s2_reg;
  logic [GPIO_WIDTH-1:0] prev_reg;
  logic [1:0]            arm_reg;
  logic [GPIO_WIDTH-1:0] pin_val;
  logic [GPIO_WIDTH-1:0] capture;
  logic [31:0]           lane_mask;
  logic [GPIO_WIDTH-1:0] wr_mask;
  logic [GPIO_WIDTH-1:0] wr_data;
  logic [31:0]           rd_data;
  logic [2:0]            reg_idx;
  logic                  req;
  logic                  wr;
  logic                  unused_bits;

  // Low address bits and (for narrow banks) upper data bits carry no meaning.
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, 32'(DEBOUNCE_CYCLES)};

  // Expand byte-lane enables into a bit mask.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  assign wr_mask = lane_mask[GPIO_WIDTH-1:0];
  assign wr_data = wb_dat_i[GPIO_WIDTH-1:0];
  assign reg_idx = wb_adr_i[4:2];
  // Ack low is part of the request so acks can never be back to back.
  assign req     = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign wr      = req & wb_we_i;

  // Two-flop synchroniser and post-reset arm counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_reg  <= '0;
      s2_reg  <= '0;
      arm_reg <= 2'd0;
    end else begin
      s1_reg  <= gpio_i;
      s2_reg  <= s1_reg;
      if (arm_reg != 2'd3) arm_reg <= arm_reg + 2'd1;
    end
  end

`ifdef WB_GPIO_DEBOUNCE_EN
  // Any change on the synchronised bus restarts the shared stability count;
  // the filtered value follows the candidate once it has held long enough.
  logic [15:0]           db_cnt_reg;
  logic [GPIO_WIDTH-1:0] cand_reg;
  logic [GPIO_WIDTH-1:0] filt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt_reg <= 16'd0;
      cand_reg   <= '0;
      filt_reg   <= '0;
    end else if (s2_reg != cand_reg) begin
      cand_reg   <= s2_reg;
      db_cnt_reg <= 16'd1;
    end else if (db_cnt_reg >= 16'(DEBOUNCE_CYCLES - 1)) begin
      filt_reg   <= cand_reg;
    end else begin
      db_cnt_reg <= db_cnt_reg + 16'd1;
    end
  end

  assign pin_val = filt_reg;
`else
  assign pin_val = s2_reg;
`endif

  // Per-pin edge qualification; suppressed until the history is valid.
  generate
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_edge
      assign capture[gi] = (arm_reg == 2'd3) &&
                           (edge_reg[gi] ? ( pin_val[gi] & ~prev_reg[gi])
                                         : (~pin_val[gi] &  prev_reg[gi]));
    end
  endgenerate

  // A new edge wins over a simultaneous write-1-to-clear.
  always_comb begin
    status_next = status_reg;
    if (wr && reg_idx == REG_STATUS)
      status_next = status_reg & ~(wr_data & wr_mask);
    status_next = status_next | capture;
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_IN:     rd_data[GPIO_WIDTH-1:0] = pin_val;
      REG_OUT:    rd_data[GPIO_WIDTH-1:0] = out_reg;
      REG_DIR:    rd_data[GPIO_WIDTH-1:0] = dir_reg;
      REG_MASK:   rd_data[GPIO_WIDTH-1:0] = mask_reg;
      REG_EDGE:   rd_data[GPIO_WIDTH-1:0] = edge_reg;
      REG_STATUS: rd_data[GPIO_WIDTH-1:0] = status_reg;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      irq_reg    <= 1'b0;
      out_reg    <= '0;
      dir_reg    <= '0;
      mask_reg   <= '0;
      edge_reg   <= '0;
      status_reg <= '0;
      prev_reg   <= '0;
    end else begin
      ack_reg    <= req;
      dat_reg    <= req ? rd_data : 32'd0;
      irq_reg    <= |(status_reg & mask_reg);
      status_reg <= status_next;
      prev_reg   <= pin_val;
      if (wr) begin
        case (reg_idx)
          REG_OUT:  out_reg  <= (out_reg  & ~wr_mask) | (wr_data & wr_mask);
          REG_DIR:  dir_reg  <= (dir_reg  & ~wr_mask) | (wr_data & wr_mask);
          REG_MASK: mask_reg <= (mask_reg & ~wr_mask) | (wr_data & wr_mask);
          REG_EDGE: edge_reg <= (edge_reg & ~wr_mask) | (wr_data & wr_mask);
          default:  ;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;
  assign irq_o    = irq_reg;
  assign gpio_o   = out_reg;
  assign gpio_oe  = dir_reg;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Testbench for wb_gpio_bank (default build): directed scenarios followed by
// random bus traffic and pin activity, all checked against a reference model
// that reasons over the recorded pin history rather than flop stages.

module tb_wb_gpio_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [31:0] gpio_i = '0;
  logic [31:0] gpio_o;
  logic [31:0] gpio_oe;
  logic        irq_o;

  wb_gpio_bank #(.GPIO_WIDTH(32), .DEBOUNCE_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pins seen before edge k are stored in hist[k]
  // (k counted from the first edge after reset release).
  logic [31:0] hist [0:16383];
  int          n = 0;
  logic [31:0] m_out, m_dir, m_mask, m_edge, m_status, m_dat;
  logic        m_ack, m_irq;

  task automatic model_edge();
    logic [31:0] in_now, cap, bm, clr, rd;
    logic        req, now_b, old_b;
    if (reset) begin
      n = 0;
      m_out = '0; m_dir = '0; m_mask = '0; m_edge = '0; m_status = '0;
      m_dat = '0; m_ack = 1'b0; m_irq = 1'b0;
      return;
    end
    n++;
    hist[n] = gpio_i;
    // A pin is readable two clocks after it is applied.
    in_now = (n >= 3) ? hist[n-2] : 32'd0;
    cap = '0;
    // Edges are only reported once the history spans a full compare window.
    if (n >= 4) begin
      for (int i = 0; i < 32; i++) begin
        now_b = hist[n-2][i];
        old_b = hist[n-3][i];
        if (m_edge[i] ? (now_b && !old_b) : (!now_b && old_b)) cap[i] = 1'b1;
      end
    end
    req = wb_cyc_i && wb_stb_i && !m_ack;
    rd  = '0;
    clr = '0;
    for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{wb_sel_i[b]}};
    if (req) begin
      case (wb_adr_i[4:2])
        3'd0: rd = in_now;
        3'd1: rd = m_out;
        3'd2: rd = m_dir;
        3'd3: rd = m_mask;
        3'd4: rd = m_edge;
        3'd5: rd = m_status;
        default: rd = '0;
      endcase
    end
    m_irq = |(m_status & m_mask);
    if (req && wb_we_i) begin
      case (wb_adr_i[4:2])
        3'd1: m_out  = (m_out  & ~bm) | (wb_dat_i & bm);
        3'd2: m_dir  = (m_dir  & ~bm) | (wb_dat_i & bm);
        3'd3: m_mask = (m_mask & ~bm) | (wb_dat_i & bm);
        3'd4: m_edge = (m_edge & ~bm) | (wb_dat_i & bm);
        3'd5: clr    = wb_dat_i & bm;
        default: ;
      endcase
    end
    m_status = (m_status & ~clr) | cap;
    m_ack = req;
    m_dat = rd;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
    chk("dat_o", wb_dat_o, m_dat);
    chk("gpio_o", gpio_o, m_out);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("irq", {31'd0, irq_o}, {31'd0, m_irq});
  endtask

  task automatic ticks(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  task automatic xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      lat++;
      if (wb_ack_o) break;
    end
    if (!wb_ack_o) chk("ack_timeout", 32'd0, 32'd1);
    rdata = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    $display("xfer we=%0d adr=%h wdat=%h sel=%h rdat=%h lat=%0d", we, adr, dat, sel, rdata, lat);
  endtask

  logic [31:0] rdata;
  int          lat;
  int          cyc_cnt;

  initial begin
    // Reset with all pins high; no spurious edges may appear.
    gpio_i = 32'hFFFF_FFFF;
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    ticks(10);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_oe", gpio_oe, 32'd0);
    chk("rst_out", gpio_o, 32'd0);
    xfer(1'b0, 5'h14, 32'd0, 4'hF, rdata, lat);
    chk("rst_status", rdata, 32'd0);
    tick();
    xfer(1'b0, 5'h00, 32'd0, 4'hF, rdata, lat);
    chk("rst_in", rdata, 32'hFFFF_FFFF);
    tick();

    // DIR and OUT with a single byte lane.
    xfer(1'b1, 5'h08, 32'h0000_000F, 4'hF, rdata, lat);
    chk("dir_lat", lat, 32'd1);
    tick();
    chk("ack_pulse", {31'd0, wb_ack_o}, 32'd0);
    xfer(1'b1, 5'h04, 32'hAABB_CC05, 4'b0001, rdata, lat);
    chk("dir_oe", gpio_oe, 32'h0000_000F);
    chk("out_val", gpio_o, 32'h0000_0005);
    tick();
    xfer(1'b0, 5'h05, 32'd0, 4'hF, rdata, lat);
    chk("out_rd", rdata, 32'h0000_0005);
    tick();

    // Rising edge on pin 0 with interrupt enabled.
    gpio_i = 32'd0;
    ticks(5);
    xfer(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, rdata, lat);
    tick();
    xfer(1'b1, 5'h0C, 32'h1, 4'hF, rdata, lat);
    tick();
    xfer(1'b1, 5'h10, 32'h1, 4'hF, rdata, lat);
    ticks(2);
    gpio_i = 32'h1;
    cyc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cyc_cnt++;
      if (irq_o) break;
    end
    chk("irq_rise_cycles", cyc_cnt, 32'd4);
    xfer(1'b0, 5'h14, 32'd0, 4'hF, rdata, lat);
    chk("status_pin0", rdata, 32'h1);
    tick();
    xfer(1'b1, 5'h14, 32'h1, 4'hF, rdata, lat);
    chk("irq_hold", {31'd0, irq_o}, 32'd1);
    tick();
    chk("irq_fall", {31'd0, irq_o}, 32'd0);

    // Falling edge on pin 3, masked, then unmasked.
    gpio_i = 32'h9;
    ticks(5);
    gpio_i = 32'h1;
    ticks(5);
    xfer(1'b0, 5'h14, 32'd0, 4'hF, rdata, lat);
    chk("status_pin3", rdata, 32'h8);
    chk("irq_masked", {31'd0, irq_o}, 32'd0);
    tick();
    xfer(1'b1, 5'h0C, 32'h8, 4'hF, rdata, lat);
    tick();
    chk("irq_unmask", {31'd0, irq_o}, 32'd1);

    // Clear and new edge collide on pin 0: the edge wins.
    xfer(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, rdata, lat);
    gpio_i = 32'h0;
    ticks(4);
    gpio_i = 32'h1;
    ticks(2);
    xfer(1'b1, 5'h14, 32'h1, 4'hF, rdata, lat);
    tick();
    xfer(1'b0, 5'h14, 32'd0, 4'hF, rdata, lat);
    chk("set_wins", rdata & 32'h1, 32'h1);
    tick();

    // Unused offsets read zero.
    xfer(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, rdata, lat);
    tick();
    xfer(1'b0, 5'h18, 32'd0, 4'hF, rdata, lat);
    chk("unused_rd", rdata, 32'd0);
    tick();

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) == 0) begin
        ticks($urandom_range(1, 3));
      end else begin
        xfer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             4'($urandom_range(0, 15)), rdata, lat);
      end
    end
    ticks(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
